// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - operand/result valid-ready bundle for mul_seq_ctrl
interface mul_seq_ctrl_if #(
  parameter int A_W = 8,
  parameter int B_W = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic [A_W-1:0]       a_in;
  logic [B_W-1:0]       b_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [A_W+B_W-1:0]   p_out;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, p_out
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, p_out
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - digit-serial A_W x B_W multiplier around one shared 4x3 core
// Optional MUL_SEQ_ZERO_SKIP_EN: zero operands bypass RUN and finish one cycle after accept.
module mul_core_4x3 (
  input  logic [3:0] a,
  input  logic [2:0] b,
  output logic [6:0] p
);
  always_comb begin
    p = '0;
    for (int k = 0; k < 3; k++) begin
      if (b[k]) p = p + (7'(a) << k);
    end
  end
endmodule

module mul_seq_ctrl #(
  parameter int A_W = 8,
  parameter int B_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_seq_ctrl_if.slave  bus,
  output logic           busy
);
  localparam int NA  = A_W / 4;
  localparam int NB  = B_W / 3;
  localparam int P_W = A_W + B_W;
  localparam int IW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int JW  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(NA - 1);
  localparam logic [JW-1:0] J_LAST = JW'(NB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state;
  logic [A_W-1:0] a_reg;
  logic [B_W-1:0] b_reg;
  logic [P_W-1:0] acc;
  logic [P_W-1:0] p_reg;
  logic [IW-1:0]  i_cnt;
  logic [JW-1:0]  j_cnt;

  logic [A_W-1:0] a_sh;
  logic [B_W-1:0] b_sh;
  logic [3:0]     a_dig;
  logic [2:0]     b_dig;
  logic [6:0]     pp;
  logic [P_W-1:0] pp_ext;
  logic [P_W-1:0] acc_next;
  logic           last_pass;
  logic           accept;
  int             shamt;

  // Digit i of A sits at bit 4i, digit j of B at bit 3j; their product weight is the sum.
  always_comb begin
    a_sh     = a_reg >> (4 * int'(i_cnt));
    b_sh     = b_reg >> (3 * int'(j_cnt));
    a_dig    = a_sh[3:0];
    b_dig    = b_sh[2:0];
    shamt    = 4 * int'(i_cnt) + 3 * int'(j_cnt);
    pp_ext   = P_W'(pp) << shamt;
    acc_next = acc + pp_ext;
  end

  mul_core_4x3 u_core (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  assign last_pass     = (i_cnt == I_LAST) && (j_cnt == J_LAST);
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.p_out     = p_reg;
  assign busy          = (state != S_IDLE);
  assign accept        = bus.in_valid && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      p_reg <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_reg <= bus.a_in;
            b_reg <= bus.b_in;
            acc   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
`ifdef MUL_SEQ_ZERO_SKIP_EN
            if ((bus.a_in == '0) || (bus.b_in == '0)) begin
              p_reg <= '0;
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          acc <= acc_next;
          // i walks the A digits fastest; j advances once per full sweep of A.
          if (last_pass) begin
            p_reg <= acc_next;
            state <= S_DONE;
          end else if (i_cnt == I_LAST) begin
            i_cnt <= '0;
            j_cnt <= j_cnt + 1'b1;
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
